// File: rtl/regfile_arb_pkg.sv
// Shared types and helpers for the register file write-port arbiter.
// State encoding, default widths and the round-robin priority mask.
package regfile_arb_pkg;

   localparam int REG_COUNT = 32;
   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 32;
   localparam int MAX_REQ   = 8;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Bits at or above ptr are set: the "this lap" half of the rotation.
   function automatic logic [MAX_REQ-1:0] rr_mask(input logic [2:0] ptr);
      rr_mask = ~((MAX_REQ'(1) << ptr) - MAX_REQ'(1));
   endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Rotate-priority picker: first set request at or after ptr, with wrap.
// Purely combinational; emits one-hot grant, its index and an any flag.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);
   import regfile_arb_pkg::*;

   logic [MAX_REQ-1:0] mask;
   logic [N-1:0]       hi;
   logic [IW-1:0]      lo_idx;
   logic [IW-1:0]      hi_idx;

   // Prefer the lowest request at or above ptr, else the lowest overall.
   always_comb begin
      mask   = rr_mask(3'(ptr_i));
      hi     = req_i & mask[N-1:0];
      lo_idx = '0;
      hi_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) lo_idx = IW'(i);
         if (hi[i])    hi_idx = IW'(i);
      end
      any_o = |req_i;
      idx_o = (|hi) ? hi_idx : lo_idx;
      gnt_o = any_o ? (N'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter with burst lock for the register file write port.
// Build option RFARB_R0_DISCARD_EN suppresses wr_en for writes to r0.
module regfile_wr_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic                        wr_stall,
   output logic                        wr_en,
   output logic [ADDR_W-1:0]           wr_addr,
   output logic [DATA_W-1:0]           wr_data,
   output logic [$clog2(NUM_REQ)-1:0]  wr_src
);
   import regfile_arb_pkg::*;

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(LOCK_MAX + 1);

   arb_state_e       state_q;
   logic [IW-1:0]    ptr_q;
   logic [IW-1:0]    owner_q;
   logic [CW-1:0]    beat_q;

   logic             wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [IW-1:0]    wr_src_q;

   logic [NUM_REQ-1:0] pick_req;
   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]    idx;
   logic             any;
   logic             accept;
   logic             lock_beat;
   logic [IW-1:0]    next_ptr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic             r0_drop;

   // While locked only the owner is visible to the picker.
   always_comb begin
      pick_req = req_valid;
      if (state_q == LOCKED) begin
         pick_req = req_valid & (NUM_REQ'(1) << owner_q);
      end
   end

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req_i (pick_req),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (idx),
      .any_o (any)
   );

   // Grant qualification and selection of the winning beat.
   always_comb begin
      accept    = any & ~wr_stall;
      req_ready = accept ? gnt : '0;
      lock_beat = req_lock[idx];
      next_ptr  = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
      sel_addr  = req_addr[idx*ADDR_W +: ADDR_W];
      sel_data  = req_data[idx*DATA_W +: DATA_W];
`ifdef RFARB_R0_DISCARD_EN
      r0_drop   = (sel_addr == '0);
`else
      r0_drop   = 1'b0;
`endif
   end

   // Arbitration FSM: pointer, lock owner and burst beat count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB;
         ptr_q   <= '0;
         owner_q <= '0;
         beat_q  <= '0;
      end else if (accept) begin
         unique case (state_q)
            ARB: begin
               if (lock_beat && LOCK_MAX > 1) begin
                  state_q <= LOCKED;
                  owner_q <= idx;
                  beat_q  <= CW'(1);
               end else begin
                  ptr_q <= next_ptr;
               end
            end
            LOCKED: begin
               if (!lock_beat || beat_q == CW'(LOCK_MAX - 1)) begin
                  state_q <= ARB;
                  ptr_q   <= next_ptr;
                  beat_q  <= '0;
               end else begin
                  beat_q <= beat_q + CW'(1);
               end
            end
            default: state_q <= ARB;
         endcase
      end
   end

   // Registered write stage: one-cycle wr_en pulse, fields hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_src_q  <= '0;
      end else begin
         wr_en_q <= accept & ~r0_drop;
         if (accept) begin
            wr_addr_q <= sel_addr;
            wr_data_q <= sel_data;
            wr_src_q  <= idx;
         end
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign wr_src  = wr_src_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (NUM_REQ=4, LOCK_MAX=4).
// Expected grants and write fields are hand-derived per scenario.
module tb_regfile_wr_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_lock;
   logic [19:0]  req_addr;
   logic [127:0] req_data;
   logic [3:0]   req_ready;
   logic         wr_stall;
   logic         wr_en;
   logic [4:0]   wr_addr;
   logic [31:0]  wr_data;
   logic [1:0]   wr_src;

   int checks = 0;
   int failures = 0;

   regfile_wr_arbiter #(
      .NUM_REQ  (4),
      .ADDR_W   (5),
      .DATA_W   (32),
      .LOCK_MAX (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_lock  (req_lock),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wr_stall  (wr_stall),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_src    (wr_src)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      req_addr  = '0;
      req_data  = '0;
      wr_stall  = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0
          || wr_src !== 2'd0) begin
         failures++;
         $display("FAIL reset_outputs en=%b addr=%0d data=%h src=%0d want 0",
                  wr_en, wr_addr, wr_data, wr_src);
      end
      checks++;
      if (req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ready got=%b want=0000", req_ready);
      end
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < 4; i++) begin
         req_addr[i*5 +: 5]   = 5'(i + 1);
         req_data[i*32 +: 32] = 32'h1000 + 32'(i);
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (req_ready !== (4'b0001 << k)) begin
            failures++;
            $display("FAIL rr_ready k=%0d got=%b want=%b",
                     k, req_ready, 4'b0001 << k);
         end
         step();
         checks++;
         if (wr_en !== 1'b1 || wr_src !== 2'(k) || wr_addr !== 5'(k + 1)
             || wr_data !== 32'h1000 + 32'(k)) begin
            failures++;
            $display("FAIL rr_write k=%0d en=%b src=%0d addr=%0d data=%h",
                     k, wr_en, wr_src, wr_addr, wr_data);
         end
      end
      req_valid = '0;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL idle_ready got=%b want=0000", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b0 || wr_addr !== 5'd4 || wr_src !== 2'd3) begin
         failures++;
         $display("FAIL idle_hold en=%b addr=%0d src=%0d want 0/4/3",
                  wr_en, wr_addr, wr_src);
      end
      req_valid = 4'b1111;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL ptr_wrap got=%b want=0001", req_ready);
      end
      req_valid = '0;
   endtask

   task automatic test_single_write();
      req_addr[1*5 +: 5]   = 5'd7;
      req_data[1*32 +: 32] = 32'hDEAD_BEEF;
      req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL single_ready got=%b want=0010", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'hDEAD_BEEF
          || wr_src !== 2'd1) begin
         failures++;
         $display("FAIL single_write en=%b addr=%0d data=%h src=%0d",
                  wr_en, wr_addr, wr_data, wr_src);
      end
      req_valid = '0;
   endtask

   task automatic test_lock();
      req_valid = 4'b1111;
      req_lock  = 4'b0100;
      for (int b = 0; b < 4; b++) begin
         if (b == 2) begin
            req_valid = 4'b1011;
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
               failures++;
               $display("FAIL lock_owner_idle ready=%b want=0000", req_ready);
            end
            step();
            checks++;
            if (wr_en !== 1'b0) begin
               failures++;
               $display("FAIL lock_owner_idle_en got=%b want=0", wr_en);
            end
            req_valid = 4'b1111;
         end
         #1;
         checks++;
         if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL lock_ready beat=%0d got=%b want=0100",
                     b, req_ready);
         end
         step();
         checks++;
         if (wr_en !== 1'b1 || wr_src !== 2'd2) begin
            failures++;
            $display("FAIL lock_write beat=%0d en=%b src=%0d want 1/2",
                     b, wr_en, wr_src);
         end
      end
      req_lock = '0;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         failures++;
         $display("FAIL lock_release got=%b want=1000", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_src !== 2'd3) begin
         failures++;
         $display("FAIL lock_after en=%b src=%0d want 1/3", wr_en, wr_src);
      end
      req_valid = '0;
   endtask

   task automatic test_stall();
      req_valid = 4'b1111;
      wr_stall  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL stall_ready c=%0d got=%b want=0000", c, req_ready);
         end
         step();
         checks++;
         if (wr_en !== 1'b0) begin
            failures++;
            $display("FAIL stall_en c=%0d got=%b want=0", c, wr_en);
         end
      end
      wr_stall = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL stall_resume got=%b want=0001", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_src !== 2'd0) begin
         failures++;
         $display("FAIL stall_write en=%b src=%0d want 1/0", wr_en, wr_src);
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_reset_mid_lock();
      req_valid = 4'b0010;
      req_lock  = 4'b0010;
      step();
      step();
      rst       = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      step();
      rst = 1'b0;
      checks++;
      if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_src !== 2'd0) begin
         failures++;
         $display("FAIL midlock_reset en=%b addr=%0d src=%0d want 0/0/0",
                  wr_en, wr_addr, wr_src);
      end
      req_valid = 4'b1111;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL midlock_grant got=%b want=0001", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_src !== 2'd0) begin
         failures++;
         $display("FAIL midlock_write en=%b src=%0d want 1/0", wr_en, wr_src);
      end
      req_valid = '0;
   endtask

   task automatic test_back_to_back();
      req_addr[0*5 +: 5]   = 5'd9;
      req_addr[1*5 +: 5]   = 5'd9;
      req_data[0*32 +: 32] = 32'hAAAA_0000;
      req_data[1*32 +: 32] = 32'hBBBB_1111;
      req_valid = 4'b0011;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL b2b_first got=%b want=0010", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'hBBBB_1111
          || wr_src !== 2'd1) begin
         failures++;
         $display("FAIL b2b_write1 en=%b addr=%0d data=%h src=%0d",
                  wr_en, wr_addr, wr_data, wr_src);
      end
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL b2b_second got=%b want=0001", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'hAAAA_0000
          || wr_src !== 2'd0) begin
         failures++;
         $display("FAIL b2b_write2 en=%b addr=%0d data=%h src=%0d",
                  wr_en, wr_addr, wr_data, wr_src);
      end
      req_valid = '0;
   endtask

   task automatic test_r0();
      logic exp_en;
`ifdef RFARB_R0_DISCARD_EN
      exp_en = 1'b0;
`else
      exp_en = 1'b1;
`endif
      req_addr[2*5 +: 5]   = 5'd0;
      req_data[2*32 +: 32] = 32'h5555_AAAA;
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL r0_ready got=%b want=0100", req_ready);
      end
      step();
      checks++;
      if (wr_en !== exp_en || wr_addr !== 5'd0 || wr_data !== 32'h5555_AAAA
          || wr_src !== 2'd2) begin
         failures++;
         $display("FAIL r0_write en=%b addr=%0d data=%h src=%0d want en=%b",
                  wr_en, wr_addr, wr_data, wr_src, exp_en);
      end
      req_valid = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_write();
      test_lock();
      test_stall();
      test_reset_mid_lock();
      test_back_to_back();
      test_r0();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
